// File: rtl/iq_channel_emu.sv
// I/Q loopback channel emulator: quarter-turn rotation, gain, DC offset,
// LFSR noise and a programmable sample delay between Tx DAC and Rx ADC.
module iq_channel_emu #(
  parameter int          DW        = 12,
  parameter int          NOISE_W   = 5,
  parameter int          MAX_DELAY = 16,
  parameter logic [15:0] SEED_I    = 16'hACE1,
  parameter logic [15:0] SEED_Q    = 16'h1D2C
) (
  input  logic                         clk_16M384,
  input  logic                         rst_16M384,
  input  logic signed [DW-1:0]         DAC_I,
  input  logic signed [DW-1:0]         DAC_Q,
  input  logic                         DAC_vld,
  input  logic [1:0]                   ROT,
  input  logic [3:0]                   GAIN,
  input  logic signed [DW-1:0]         DC_OFFSET,
  input  logic                         NOISE_EN,
  input  logic [$clog2(MAX_DELAY)-1:0] DELAY,
  output logic signed [DW-1:0]         ADC_I,
  output logic signed [DW-1:0]         ADC_Q,
  output logic                         ADC_vld,
  output logic                         SAT
);

  localparam int AW = $clog2(MAX_DELAY);
  localparam int PW = DW + 5;
  localparam int SW = DW + 6;
  localparam logic signed [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef struct packed {
    logic signed [DW-1:0] i;
    logic signed [DW-1:0] q;
    logic                 sat;
  } smp_t;

  // Returns {clipped, -x}; the most negative code has no positive twin.
  function automatic logic [DW:0] neg_sat(input logic signed [DW-1:0] x);
    if (x == S_MIN) return {1'b1, S_MAX};
    return {1'b0, -x};
  endfunction

  function automatic logic [DW:0] clip(input logic signed [SW-1:0] v);
    if (v > SW'(S_MAX)) return {1'b1, S_MAX};
    if (v < SW'(S_MIN)) return {1'b1, S_MIN};
    return {1'b0, v[DW-1:0]};
  endfunction

  // ---------------------------------------------------------------- stage 1
  logic [DW:0]          w_neg_i, w_neg_q;
  logic signed [DW-1:0] w_rot_i, w_rot_q;
  logic                 w_rot_sat;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_neg_i   = neg_sat(DAC_I);
    w_neg_q   = neg_sat(DAC_Q);
    w_rot_i   = DAC_I;
    w_rot_q   = DAC_Q;
    w_rot_sat = 1'b0;
    case (ROT)
      2'd1: begin
        w_rot_i   = DAC_Q;
        w_rot_q   = w_neg_i[DW-1:0];
        w_rot_sat = w_neg_i[DW];
      end
      2'd2: begin
        w_rot_i   = w_neg_i[DW-1:0];
        w_rot_q   = w_neg_q[DW-1:0];
        w_rot_sat = w_neg_i[DW] | w_neg_q[DW];
      end
      2'd3: begin
        w_rot_i   = w_neg_q[DW-1:0];
        w_rot_q   = DAC_I;
        w_rot_sat = w_neg_q[DW];
      end
      default: ;
    endcase
  end

  logic signed [DW-1:0] r_s1_i, r_s1_q;
  logic                 r_s1_vld, r_s1_sat;

  always_ff @(posedge clk_16M384) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    if (rst_16M384) begin
      r_s1_i   <= '0;
      r_s1_q   <= '0;
      r_s1_vld <= 1'b0;
      r_s1_sat <= 1'b0;
    end else begin
      r_s1_i   <= w_rot_i;
      r_s1_q   <= w_rot_q;
      r_s1_vld <= DAC_vld;
      r_s1_sat <= w_rot_sat;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic signed [PW-1:0] w_gain_ext;
  logic signed [PW-1:0] r_s2_p_i, r_s2_p_q;
  logic                 r_s2_vld, r_s2_sat;

  assign w_gain_ext = {{(PW-4){1'b0}}, GAIN};

  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      r_s2_p_i <= '0;
      r_s2_p_q <= '0;
      r_s2_vld <= 1'b0;
      r_s2_sat <= 1'b0;
    end else begin
      r_s2_p_i <= PW'(r_s1_i) * w_gain_ext;
      r_s2_p_q <= PW'(r_s1_q) * w_gain_ext;
      r_s2_vld <= r_s1_vld;
      r_s2_sat <= r_s1_sat;
    end
  end

  // ---------------------------------------------------------------- noise
  logic [15:0] r_lfsr_i, r_lfsr_q;

  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      r_lfsr_i <= SEED_I;
      r_lfsr_q <= SEED_Q;
    end else begin
      r_lfsr_i <= {r_lfsr_i[0] ^ r_lfsr_i[2] ^ r_lfsr_i[3] ^ r_lfsr_i[5], r_lfsr_i[15:1]};
      r_lfsr_q <= {r_lfsr_q[0] ^ r_lfsr_q[2] ^ r_lfsr_q[3] ^ r_lfsr_q[5], r_lfsr_q[15:1]};
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic signed [SW-1:0] w_noise_i, w_noise_q, w_sum_i, w_sum_q;
  logic [DW:0]          w_clip_i, w_clip_q;
  smp_t                 w_s3;
  logic                 w_s3_vld;

  always_comb begin
    w_noise_i = '0;
    w_noise_q = '0;
    if (NOISE_EN) begin
      w_noise_i = {{(SW-NOISE_W){1'b0}}, r_lfsr_i[NOISE_W-1:0]};
      w_noise_q = {{(SW-NOISE_W){1'b0}}, r_lfsr_q[NOISE_W-1:0]};
    end
    // Arithmetic shift floors, so GAIN/4 rounds toward minus infinity.
    w_sum_i  = (SW'(r_s2_p_i) >>> 2) + SW'(DC_OFFSET) + w_noise_i;
    w_sum_q  = (SW'(r_s2_p_q) >>> 2) + SW'(DC_OFFSET) + w_noise_q;
    w_clip_i = clip(w_sum_i);
    w_clip_q = clip(w_sum_q);
    w_s3     = '0;
    w_s3_vld = r_s2_vld;
    if (r_s2_vld) begin
      w_s3.i   = w_clip_i[DW-1:0];
      w_s3.q   = w_clip_q[DW-1:0];
      w_s3.sat = w_clip_i[DW] | w_clip_q[DW] | r_s2_sat;
    end
  end

  // ---------------------------------------------------------------- delay
  smp_t             r_buf [MAX_DELAY];
  logic [MAX_DELAY-1:0] r_buf_vld;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    w_rd_ptr;

  assign w_rd_ptr = r_wr_ptr - DELAY;

  // NOTE: sample storage is deliberately left unreset; only the per-slot
  // valid bits are cleared, and the read mux zeroes any slot marked invalid.
  always_ff @(posedge clk_16M384) begin
    r_buf[r_wr_ptr] <= w_s3;
  end

  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      r_buf_vld <= '0;
      r_wr_ptr  <= '0;
    end else begin
      r_buf_vld[r_wr_ptr] <= w_s3_vld;
      r_wr_ptr            <= r_wr_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      ADC_I   <= '0;
      ADC_Q   <= '0;
      ADC_vld <= 1'b0;
      SAT     <= 1'b0;
    end else if (DELAY == '0) begin
      ADC_I   <= w_s3.i;
      ADC_Q   <= w_s3.q;
      ADC_vld <= w_s3_vld;
      SAT     <= w_s3.sat;
    end else if (r_buf_vld[w_rd_ptr]) begin
      ADC_I   <= r_buf[w_rd_ptr].i;
      ADC_Q   <= r_buf[w_rd_ptr].q;
      ADC_vld <= 1'b1;
      SAT     <= r_buf[w_rd_ptr].sat;
    end else begin
      ADC_I   <= '0;
      ADC_Q   <= '0;
      ADC_vld <= 1'b0;
      SAT     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iq_channel_emu.sv
// Self-checking bench for iq_channel_emu: directed steps plus random traffic
// against a history-based reference of the channel's transfer rules.
module tb_iq_channel_emu;

  localparam int NCYC = 4096;
  localparam logic [15:0] SEED_I = 16'hACE1;
  localparam logic [15:0] SEED_Q = 16'h1D2C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic signed [11:0]  dac_i, dac_q, dc_off;
  logic                dac_vld, nen;
  logic [1:0]          rot;
  logic [3:0]          gain, dly;
  logic signed [11:0]  adc_i, adc_q;
  logic                adc_vld, sat;

  iq_channel_emu dut (
    .clk_16M384 (clk),
    .rst_16M384 (rst),
    .DAC_I      (dac_i),
    .DAC_Q      (dac_q),
    .DAC_vld    (dac_vld),
    .ROT        (rot),
    .GAIN       (gain),
    .DC_OFFSET  (dc_off),
    .NOISE_EN   (nen),
    .DELAY      (dly),
    .ADC_I      (adc_i),
    .ADC_Q      (adc_q),
    .ADC_vld    (adc_vld),
    .SAT        (sat)
  );

  // Stimulus history, one entry per clock edge; h_li/h_lq hold the
  // reference noise generator state after that edge.
  bit          h_rst [NCYC];
  bit          h_vld [NCYC];
  bit          h_nen [NCYC];
  int          h_i [NCYC], h_q [NCYC], h_rot [NCYC], h_gain [NCYC];
  int          h_off [NCYC], h_dly [NCYC];
  logic [15:0] h_li [NCYC], h_lq [NCYC];

  int n        = 0;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction

  function automatic int clamp12(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  // Output at edge e is the sample whose sum/clip stage completed at edge
  // w = e - DELAY; it entered at w-2, saw GAIN at w-1 and offset/noise at w.
  function automatic logic [25:0] model(input int e);
    int d, w, xi, xq, ri, rq, vi, vq, ni, nq;
    bit s;
    d = h_dly[e];
    w = e - d;
    if (w - 2 < 0) return '0;
    for (int k = w - 2; k <= e; k++) if (h_rst[k]) return '0;
    if (!h_vld[w-2]) return '0;
    xi = h_i[w-2];
    xq = h_q[w-2];
    case (h_rot[w-2])
      0:       begin ri = xi;  rq = xq;  end
      1:       begin ri = xq;  rq = -xi; end
      2:       begin ri = -xi; rq = -xq; end
      default: begin ri = -xq; rq = xi;  end
    endcase
    s  = (ri > 2047) || (rq > 2047);
    ri = clamp12(ri);
    rq = clamp12(rq);
    ni = h_nen[w] ? int'(h_li[w-1]) % 32 : 0;
    nq = h_nen[w] ? int'(h_lq[w-1]) % 32 : 0;
    vi = ((ri * h_gain[w-1]) >>> 2) + h_off[w] + ni;
    vq = ((rq * h_gain[w-1]) >>> 2) + h_off[w] + nq;
    s  = s || (clamp12(vi) != vi) || (clamp12(vq) != vq);
    return {12'(clamp12(vi)), 12'(clamp12(vq)), 1'b1, s};
  endfunction

  task automatic tick();
    logic [25:0] exp_v;
    if (n >= NCYC) begin
      $display("FAIL cycle_budget: observed %0d cycles required < %0d", n, NCYC);
      $fatal(1);
    end
    h_rst[n] = rst;  h_vld[n] = dac_vld; h_nen[n] = nen;
    h_i[n]   = int'(dac_i);  h_q[n] = int'(dac_q);
    h_rot[n] = int'(rot);    h_gain[n] = int'(gain);
    h_off[n] = int'(dc_off); h_dly[n] = int'(dly);
    @(posedge clk);
    h_li[n] = (rst || n == 0) ? SEED_I : lfsr_next(h_li[n-1]);
    h_lq[n] = (rst || n == 0) ? SEED_Q : lfsr_next(h_lq[n-1]);
    #1;
    exp_v = model(n);
    n_checks++;
    assert ({adc_i, adc_q, adc_vld, sat} === exp_v) else begin
      n_fail++;
      $error("FAIL model@%0d: observed I=%0d Q=%0d vld=%0b sat=%0b expected I=%0d Q=%0d vld=%0b sat=%0b",
             n, adc_i, adc_q, adc_vld, sat,
             $signed(exp_v[25:14]), $signed(exp_v[13:2]), exp_v[1], exp_v[0]);
    end
    n++;
  endtask

  task automatic idle(input int cycles);
    dac_vld = 1'b0;
    dac_i   = '0;
    dac_q   = '0;
    for (int k = 0; k < cycles; k++) tick();
  endtask

  task automatic send(input int i, input int q);
    dac_vld = 1'b1;
    dac_i   = 12'(i);
    dac_q   = 12'(q);
    tick();
    dac_vld = 1'b0;
  endtask

  task automatic check_out(input string tag, input int ei, input int eq,
                           input bit ev, input bit es);
    n_checks++;
    assert ({adc_i, adc_q, adc_vld, sat} === {12'(ei), 12'(eq), ev, es}) else begin
      n_fail++;
      $error("FAIL %s: observed I=%0d Q=%0d vld=%0b sat=%0b expected I=%0d Q=%0d vld=%0b sat=%0b",
             tag, adc_i, adc_q, adc_vld, sat, ei, eq, ev, es);
    end
  endtask

  task automatic check_int(input string tag, input bit ok, input int obs, input int exp);
    n_checks++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int r, input int g, input int off, input bit ne);
    rot    = 2'(r);
    gain   = 4'(g);
    dc_off = 12'(off);
    nen    = ne;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin : stim
    int mn, mx, first_i;
    bit varies;

    rst = 1'b1; dac_vld = 1'b0; dac_i = '0; dac_q = '0; dly = '0;
    set_cfg(0, 4, 0, 1'b0);
    tick();
    tick();
    check_out("reset_state", 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(3);

    // Unity path, 3-cycle latency.
    send(100, -50);
    idle(1);
    check_out("basic_early", 0, 0, 1'b0, 1'b0);
    idle(1);
    check_out("basic_lat3", 100, -50, 1'b1, 1'b0);
    idle(1);
    check_out("basic_after", 0, 0, 1'b0, 1'b0);

    // Rotation, fractional gain, negative offset.
    set_cfg(1, 3, -16, 1'b0);
    send(400, 200);
    idle(2);
    check_out("rot1_gain3", 134, -316, 1'b1, 1'b0);
    idle(2);

    // Saturation corners.
    set_cfg(0, 15, 0, 1'b0);
    send(2047, 0);
    idle(2);
    check_out("sat_gain", 2047, 0, 1'b1, 1'b1);
    idle(2);
    set_cfg(2, 4, 0, 1'b0);
    send(-2048, 0);
    idle(2);
    check_out("sat_negate", 2047, 0, 1'b1, 1'b1);
    idle(2);
    set_cfg(0, 15, -100, 1'b0);
    send(-2048, 0);
    idle(2);
    check_out("sat_low", -2048, -100, 1'b1, 1'b1);
    idle(2);

    // GAIN=0 passes only the offset.
    set_cfg(3, 0, 37, 1'b0);
    send(1234, -999);
    idle(2);
    check_out("gain_zero", 37, 37, 1'b1, 1'b0);
    idle(2);

    // Delayed ramps with vld gaps, then a long delay across pointer wrap.
    set_cfg(0, 4, 0, 1'b0);
    dly = 4'd5;
    idle(20);
    for (int k = 0; k <= 40; k++) begin
      dac_vld = (k % 5) != 3;
      dac_i   = 12'(k);
      dac_q   = 12'(-k);
      tick();
    end
    idle(20);
    dly = 4'd15;
    idle(20);
    send(77, -77);
    idle(16);
    check_out("delay15_early", 0, 0, 1'b0, 1'b0);
    idle(1);
    check_out("delay15_lat18", 77, -77, 1'b1, 1'b0);
    for (int k = 0; k <= 40; k++) begin
      dac_vld = (k % 7) != 2;
      dac_i   = 12'(k * 3);
      dac_q   = 12'(k);
      tick();
    end
    idle(20);

    // Noise only: zero input, zero offset.
    dly = '0;
    idle(20);
    set_cfg(0, 4, 0, 1'b1);
    dac_vld = 1'b1; dac_i = '0; dac_q = '0;
    mn = 1000; mx = -1000; varies = 1'b0; first_i = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (k == 3) first_i = int'(adc_i);
      if (k >= 3) begin
        if (int'(adc_i) < mn) mn = int'(adc_i);
        if (int'(adc_q) < mn) mn = int'(adc_q);
        if (int'(adc_i) > mx) mx = int'(adc_i);
        if (int'(adc_q) > mx) mx = int'(adc_q);
        if (int'(adc_i) != first_i) varies = 1'b1;
      end
    end
    check_int("noise_min", mn >= 0, mn, 0);
    check_int("noise_max", mx <= 31, mx, 31);
    check_int("noise_varies", varies, int'(varies), 1);
    nen = 1'b0;
    tick(); tick(); tick();
    check_out("noise_off", 0, 0, 1'b1, 1'b0);
    idle(4);

    // Random traffic with configuration changing mid-stream.
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 7) == 0)
        set_cfg($urandom_range(0, 3), $urandom_range(0, 15),
                ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4095) - 2048
                                            : $urandom_range(0, 200) - 100,
                1'($urandom_range(0, 1)));
      if ($urandom_range(0, 15) == 0) dly = 4'($urandom_range(0, 15));
      dac_vld = $urandom_range(0, 3) != 0;
      case ($urandom_range(0, 7))
        0:       dac_i = 12'sd2047;
        1:       dac_i = -12'sd2048;
        default: dac_i = 12'($urandom_range(0, 4095));
      endcase
      dac_q = ($urandom_range(0, 7) == 0) ? -12'sd2048 : 12'($urandom_range(0, 4095));
      tick();
    end

    // Mid-stream reset with a continuous valid stream at DELAY=3.
    dly = 4'd3;
    set_cfg(1, 5, 10, 1'b1);
    dac_vld = 1'b1;
    for (int k = 0; k < 30; k++) begin
      dac_i = 12'($urandom_range(0, 4095));
      dac_q = 12'($urandom_range(0, 4095));
      tick();
    end
    rst = 1'b1;
    tick();
    check_out("rst_clear", 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      dac_i = 12'($urandom_range(0, 4095));
      dac_q = 12'($urandom_range(0, 4095));
      tick();
      if (k == 5) check_out("rst_no_stale", 0, 0, 1'b0, 1'b0);
      if (k == 6) check_int("rst_first_valid", adc_vld === 1'b1, int'(adc_vld), 1);
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
